// File: rtl/second_chance_pkg.sv
// second_chance_pkg: default widths and the priority first-match helper shared by the forwarding stage.
package second_chance_pkg;
  localparam int DATA_WIDTH_D = 4;
  localparam int KEY_WIDTH_D = 2;
  localparam int HASH_ADR_WIDTH_D = 2;
  localparam int SHIFT_HASH_ADR_WIDTH_D = 2;
  localparam int FWD_DEPTH_D = 3;
  // Lowest set bit wins: bit 0 is the youngest candidate.
  function automatic int first_idx(input logic [31:0] hits);
    first_idx = 0;
    for (int i = 31; i >= 0; i--)
      if (hits[i]) first_idx = i;
  endfunction
endpackage

// File: rtl/fwd_history_cam.sv
// fwd_history_cam: DEPTH-entry write history with youngest-first address match and payload mux.
module fwd_history_cam #(
  parameter int ADR_W = 2,
  parameter int PAYLOAD_W = 1,
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [ADR_W-1:0]     push_adr_i,
  input  logic [PAYLOAD_W-1:0] push_pl_i,
  input  logic [ADR_W-1:0]     look_adr_i,
  input  logic [PAYLOAD_W-1:0] dflt_pl_i,
  output logic                 hit_o,
  output logic [PAYLOAD_W-1:0] pl_o
);
  import second_chance_pkg::*;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0][ADR_W-1:0] adr_q, adr_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] pl_q, pl_d;
  logic [DEPTH:0] hits;
  logic [DEPTH:0][PAYLOAD_W-1:0] cand;
  int sel;
  // The same-cycle write is candidate 0 so it overrides everything in history.
  always_comb begin
    hits[0] = push_i && push_adr_i == look_adr_i;
    cand[0] = push_pl_i;
    for (int i = 0; i < DEPTH; i++) begin
      hits[i+1] = vld_q[i] && adr_q[i] == look_adr_i;
      cand[i+1] = pl_q[i];
    end
    sel = first_idx(32'(hits));
    hit_o = |hits;
    pl_o = dflt_pl_i;
    for (int i = 0; i <= DEPTH; i++)
      if (hit_o && i == sel) pl_o = cand[i];
  end
  always_comb begin
    vld_d = vld_q;
    adr_d = adr_q;
    pl_d = pl_q;
    if (flush_i) vld_d = '0;
    else if (push_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        adr_d[i] = adr_q[i-1];
        pl_d[i] = pl_q[i-1];
      end
      vld_d[0] = 1'b1;
      adr_d[0] = push_adr_i;
      pl_d[0] = push_pl_i;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld_q <= '0;
      adr_q <= '0;
      pl_q <= '0;
    end else if (clk_en) begin
      vld_q <= vld_d;
      adr_q <= adr_d;
      pl_q <= pl_d;
    end
endmodule

// File: rtl/forward_history_updater.sv
// forward_history_updater: corrects stale table reads against recent main/next-table writes; registered result.
module forward_history_updater
  import second_chance_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int KEY_WIDTH = KEY_WIDTH_D,
  parameter int HASH_ADR_WIDTH = HASH_ADR_WIDTH_D,
  parameter int SHIFT_HASH_ADR_WIDTH = SHIFT_HASH_ADR_WIDTH_D,
  parameter int FWD_DEPTH = FWD_DEPTH_D
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic                            flush_i,
  input  logic                            lk_valid_i,
  input  logic [HASH_ADR_WIDTH-1:0]       lk_hash_adr_i,
  input  logic [KEY_WIDTH-1:0]            lk_key_i,
  input  logic [DATA_WIDTH-1:0]           lk_data_i,
  input  logic                            lk_is_valid_i,
  input  logic [SHIFT_HASH_ADR_WIDTH-1:0] lk_shift_adr_i,
  input  logic                            lk_shift_valid_i,
  input  logic                            upd_valid_i,
  input  logic [HASH_ADR_WIDTH-1:0]       upd_hash_adr_i,
  input  logic [KEY_WIDTH-1:0]            upd_key_i,
  input  logic [DATA_WIDTH-1:0]           upd_data_i,
  input  logic                            upd_is_valid_i,
  input  logic [SHIFT_HASH_ADR_WIDTH-1:0] upd_shift_adr_i,
  input  logic                            upd_shift_valid_i,
  input  logic                            nupd_valid_i,
  input  logic [SHIFT_HASH_ADR_WIDTH-1:0] nupd_hash_adr_i,
  input  logic                            nupd_is_valid_i,
  output logic                            out_valid_o,
  output logic [KEY_WIDTH-1:0]            correct_key_o,
  output logic [DATA_WIDTH-1:0]           correct_data_o,
  output logic                            correct_is_valid_o,
  output logic [SHIFT_HASH_ADR_WIDTH-1:0] correct_shift_hash_adr_o,
  output logic                            correct_shift_valid_o,
  output logic                            hit_main_o,
  output logic                            hit_shift_o
);
  localparam int PW = KEY_WIDTH + DATA_WIDTH + SHIFT_HASH_ADR_WIDTH + 2;
  localparam int RW = PW + 3;
  logic [PW-1:0] m_pl;
  logic m_hit, n_hit, n_pl;
  logic [KEY_WIDTH-1:0] m_key;
  logic [DATA_WIDTH-1:0] m_data;
  logic m_v, m_sv;
  logic [SHIFT_HASH_ADR_WIDTH-1:0] m_sadr;
  logic [RW-1:0] res_q, res_d;
  assign {m_key, m_data, m_v, m_sadr, m_sv} = m_pl;
  fwd_history_cam #(.ADR_W(HASH_ADR_WIDTH), .PAYLOAD_W(PW), .DEPTH(FWD_DEPTH)) u_main (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .push_i(upd_valid_i), .push_adr_i(upd_hash_adr_i),
    .push_pl_i({upd_key_i, upd_data_i, upd_is_valid_i, upd_shift_adr_i, upd_shift_valid_i}),
    .look_adr_i(lk_hash_adr_i),
    .dflt_pl_i({lk_key_i, lk_data_i, lk_is_valid_i, lk_shift_adr_i, lk_shift_valid_i}),
    .hit_o(m_hit), .pl_o(m_pl)
  );
  // The next-table lookup follows the possibly forwarded shift address, not the raw read.
  fwd_history_cam #(.ADR_W(SHIFT_HASH_ADR_WIDTH), .PAYLOAD_W(1), .DEPTH(FWD_DEPTH)) u_shift (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .push_i(nupd_valid_i), .push_adr_i(nupd_hash_adr_i), .push_pl_i(nupd_is_valid_i),
    .look_adr_i(m_sadr), .dflt_pl_i(m_sv),
    .hit_o(n_hit), .pl_o(n_pl)
  );
  always_comb res_d = {lk_valid_i, m_hit, n_hit, m_key, m_data, m_v, m_sadr, n_pl};
  always_ff @(posedge clk or posedge reset)
    if (reset) res_q <= '0;
    else if (clk_en) res_q <= res_d;
  assign {out_valid_o, hit_main_o, hit_shift_o, correct_key_o, correct_data_o,
          correct_is_valid_o, correct_shift_hash_adr_o, correct_shift_valid_o} = res_q;
endmodule

// File: tb/tb_forward_history_updater.sv
// tb_forward_history_updater: directed spec scenarios plus random traffic against a queue-based history model.
module tb_forward_history_updater;
  logic clk = 0, reset = 1, clk_en, flush_i;
  logic lk_valid_i, lk_is_valid_i, lk_shift_valid_i;
  logic [1:0] lk_hash_adr_i, lk_key_i, lk_shift_adr_i;
  logic [3:0] lk_data_i;
  logic upd_valid_i, upd_is_valid_i, upd_shift_valid_i;
  logic [1:0] upd_hash_adr_i, upd_key_i, upd_shift_adr_i;
  logic [3:0] upd_data_i;
  logic nupd_valid_i, nupd_is_valid_i;
  logic [1:0] nupd_hash_adr_i;
  logic out_valid_o, correct_is_valid_o, correct_shift_valid_o, hit_main_o, hit_shift_o;
  logic [1:0] correct_key_o, correct_shift_hash_adr_o;
  logic [3:0] correct_data_o;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_v = '0, save;
  typedef struct packed {logic [1:0] adr; logic [1:0] key; logic [3:0] data; logic v; logic [1:0] sadr; logic sv;} ment_t;
  typedef struct packed {logic [1:0] adr; logic v;} nent_t;
  ment_t mh[$];
  nent_t nh[$];

  forward_history_updater dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
    .lk_valid_i(lk_valid_i), .lk_hash_adr_i(lk_hash_adr_i), .lk_key_i(lk_key_i), .lk_data_i(lk_data_i),
    .lk_is_valid_i(lk_is_valid_i), .lk_shift_adr_i(lk_shift_adr_i), .lk_shift_valid_i(lk_shift_valid_i),
    .upd_valid_i(upd_valid_i), .upd_hash_adr_i(upd_hash_adr_i), .upd_key_i(upd_key_i), .upd_data_i(upd_data_i),
    .upd_is_valid_i(upd_is_valid_i), .upd_shift_adr_i(upd_shift_adr_i), .upd_shift_valid_i(upd_shift_valid_i),
    .nupd_valid_i(nupd_valid_i), .nupd_hash_adr_i(nupd_hash_adr_i), .nupd_is_valid_i(nupd_is_valid_i),
    .out_valid_o(out_valid_o), .correct_key_o(correct_key_o), .correct_data_o(correct_data_o),
    .correct_is_valid_o(correct_is_valid_o), .correct_shift_hash_adr_o(correct_shift_hash_adr_o),
    .correct_shift_valid_o(correct_shift_valid_o), .hit_main_o(hit_main_o), .hit_shift_o(hit_shift_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] outv();
    return 32'({out_valid_o, hit_main_o, hit_shift_o, correct_key_o, correct_data_o,
                correct_is_valid_o, correct_shift_hash_adr_o, correct_shift_valid_o});
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic idle();
    {clk_en, flush_i} = 2'b10;
    {lk_valid_i, lk_hash_adr_i, lk_key_i, lk_data_i, lk_is_valid_i, lk_shift_adr_i, lk_shift_valid_i} = '0;
    {upd_valid_i, upd_hash_adr_i, upd_key_i, upd_data_i, upd_is_valid_i, upd_shift_adr_i, upd_shift_valid_i} = '0;
    {nupd_valid_i, nupd_hash_adr_i, nupd_is_valid_i} = '0;
  endtask

  // Model: candidate list = same-cycle write then history newest-first; first address match wins.
  task automatic cycle();
    ment_t c[$];
    nent_t d[$];
    ment_t r, u;
    nent_t nu;
    logic hm, hs, sv;
    if (clk_en) begin
      u = '{upd_hash_adr_i, upd_key_i, upd_data_i, upd_is_valid_i, upd_shift_adr_i, upd_shift_valid_i};
      nu = '{nupd_hash_adr_i, nupd_is_valid_i};
      if (upd_valid_i) c.push_back(u);
      foreach (mh[i]) c.push_back(mh[i]);
      if (nupd_valid_i) d.push_back(nu);
      foreach (nh[i]) d.push_back(nh[i]);
      r = '{lk_hash_adr_i, lk_key_i, lk_data_i, lk_is_valid_i, lk_shift_adr_i, lk_shift_valid_i};
      hm = 0;
      foreach (c[i]) if (!hm && c[i].adr == lk_hash_adr_i) begin r = c[i]; hm = 1; end
      hs = 0;
      sv = r.sv;
      foreach (d[i]) if (!hs && d[i].adr == r.sadr) begin sv = d[i].v; hs = 1; end
      exp_v = 32'({lk_valid_i, hm, hs, r.key, r.data, r.v, r.sadr, sv});
      if (flush_i) begin
        mh.delete();
        nh.delete();
      end else begin
        if (upd_valid_i) mh.push_front(u);
        if (nupd_valid_i) nh.push_front(nu);
        if (mh.size() > 3) void'(mh.pop_back());
        if (nh.size() > 3) void'(nh.pop_back());
      end
    end
    @(posedge clk);
    #1;
    chk("outs", outv(), exp_v);
  endtask

  task automatic upd(input logic [1:0] a, input logic [3:0] dt);
    idle();
    upd_valid_i = 1; upd_hash_adr_i = a; upd_data_i = dt; upd_key_i = a; upd_is_valid_i = 1;
  endtask

  initial begin
    idle();
    #12;
    chk("reset_outs", outv(), 32'd0);
    reset = 0;
    // memory value passes when history is empty
    idle(); lk_valid_i = 1; lk_hash_adr_i = 2; lk_data_i = 4'h5;
    cycle();
    chk("pass_data", 32'(correct_data_o), 32'h5);
    chk("pass_hit", 32'({out_valid_o, hit_main_o}), 32'b10);
    // youngest of two writes to the same address wins
    upd(1, 4'hA); cycle();
    idle(); cycle();
    upd(1, 4'hC); cycle();
    idle(); lk_valid_i = 1; lk_hash_adr_i = 1; lk_data_i = 4'h3; cycle();
    chk("fwd_young", 32'({hit_main_o, correct_data_o}), 32'h1C);
    // same-cycle chained main and shift forwarding
    upd(0, 4'h1); upd_shift_adr_i = 3; upd_shift_valid_i = 0;
    nupd_valid_i = 1; nupd_hash_adr_i = 3; nupd_is_valid_i = 1;
    lk_valid_i = 1; lk_hash_adr_i = 0; lk_shift_adr_i = 1; lk_shift_valid_i = 0;
    cycle();
    chk("chain", 32'({hit_main_o, hit_shift_o, correct_shift_hash_adr_o, correct_shift_valid_o}), 32'b11111);
    // entry ages out after three newer pushes
    upd(2, 4'h7); cycle();
    for (int i = 0; i < 3; i++) begin upd(0, 4'h2); cycle(); end
    idle(); lk_valid_i = 1; lk_hash_adr_i = 2; lk_data_i = 4'h9; cycle();
    chk("aged", 32'({hit_main_o, correct_data_o}), 32'h09);
    // flush still forwards the same-cycle write but keeps nothing
    upd(1, 4'hF); flush_i = 1; lk_valid_i = 1; lk_hash_adr_i = 1; lk_data_i = 4'h4; cycle();
    chk("flush_fwd", 32'(correct_data_o), 32'hF);
    idle(); lk_valid_i = 1; lk_hash_adr_i = 1; lk_data_i = 4'h2; cycle();
    chk("flush_clr", 32'({hit_main_o, correct_data_o}), 32'h02);
    // frozen pipeline: no push, outputs held
    save = outv();
    upd(3, 4'h6); clk_en = 0; lk_valid_i = 1; lk_hash_adr_i = 3; flush_i = 1;
    cycle(); cycle();
    chk("hold", outv(), save);
    idle(); lk_valid_i = 1; lk_hash_adr_i = 3; lk_data_i = 4'h1; cycle();
    chk("no_push", 32'({hit_main_o, correct_data_o}), 32'h01);
    for (int n = 0; n < 1500; n++) begin
      clk_en = $urandom_range(7) != 0;
      flush_i = $urandom_range(11) == 0;
      {lk_valid_i, lk_hash_adr_i, lk_key_i, lk_data_i, lk_is_valid_i, lk_shift_adr_i, lk_shift_valid_i} = 13'($urandom);
      {upd_valid_i, upd_hash_adr_i, upd_key_i, upd_data_i, upd_is_valid_i, upd_shift_adr_i, upd_shift_valid_i} = 13'($urandom);
      {nupd_valid_i, nupd_hash_adr_i, nupd_is_valid_i} = 4'($urandom);
      cycle();
      if (n == 700) begin
        #2 reset = 1;
        #1 chk("async_rst", outv(), 32'd0);
        mh.delete();
        nh.delete();
        exp_v = '0;
        #2 reset = 0;
        idle(); lk_valid_i = 1; lk_hash_adr_i = 1; lk_data_i = 4'hB; cycle();
        chk("post_rst", 32'({hit_main_o, correct_data_o}), 32'h0B);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
